alu_exec_stage: RTL and testbench

Execute-stage ALU that consumes the 3-bit alucontrol code produced by the ALU decoder. It performs the selected operation on two WIDTH-bit operands and returns the result with condition flags. Results leave through a registered valid/ready output stage backed by a one-entry skid buffer. The block sits between the pipeline's ID/EX register and the EX/MEM register and absorbs one cycle of downstream stall without losing data.

---
 rtl/alu_exec_if.sv | 34 +++
 rtl/alu_exec_stage.sv | 151 +++++++++++++++
 tb/tb_alu_exec_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Handshake and data bundle between the ID/EX register, the execute-stage
// ALU and the EX/MEM register. The master drives operands and accepts
// results; the slave (the ALU stage) does the opposite.
interface alu_exec_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alucontrol;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             illegal_op;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, alucontrol, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, negative, carry, overflow,
           illegal_op, op_count
  );

  modport slave (
    input  in_valid, alucontrol, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, negative, carry, overflow,
           illegal_op, op_count
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with registered valid/ready output and a one-entry skid
// buffer. The result and flags are computed at acceptance time and stored as
// a single record, so the output register and the skid entry stay consistent.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             illegal_op;
  } res_t;

  // Evaluate one operation; reserved codes fall through to an all-zero
  // result with only illegal_op set (zero follows from the result).
  function automatic res_t alu_compute(input logic [2:0]       op,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
    res_t           r;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           add_ovf;
    logic           sub_ovf;
    sum     = {1'b0, a} + {1'b0, b};
    // a + ~b + 1: bit WIDTH is the no-borrow flag (a >= b unsigned)
    diff    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    r = '0;
    case (op)
      OP_ADD: begin
        r.result   = sum[WIDTH-1:0];
        r.carry    = sum[WIDTH];
        r.overflow = add_ovf;
      end
      OP_SUB: begin
        r.result   = diff[WIDTH-1:0];
        r.carry    = diff[WIDTH];
        r.overflow = sub_ovf;
      end
      OP_AND: begin
        r.result = a & b;
      end
      OP_OR: begin
        r.result = a | b;
      end
      OP_SLT: begin
        // signed less-than is sign of the difference corrected by overflow
        r.result   = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
        r.carry    = diff[WIDTH];
        r.overflow = sub_ovf;
      end
      default: begin
        r.illegal_op = 1'b1;
      end
    endcase
    r.zero     = (r.result == {WIDTH{1'b0}});
    r.negative = r.result[WIDTH-1];
    return r;
  endfunction

  logic             out_valid_q, out_valid_d;
  res_t             out_q, out_d;
  logic             skid_full_q, skid_full_d;
  res_t             skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept_s;
  logic             drain_s;
  res_t             new_res_s;

  assign accept_s  = bus.in_valid && !skid_full_q;
  assign drain_s   = !out_valid_q || bus.out_ready;
  assign new_res_s = alu_compute(bus.alucontrol, bus.src_a, bus.src_b);

  // Next-state for output register, skid entry and acceptance counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    skid_full_d = skid_full_q;
    skid_d      = skid_q;
    cnt_d       = cnt_q;
    if (accept_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    if (drain_s) begin
      if (skid_full_q) begin
        // in_ready is low while the skid is full, so no new input competes
        out_d       = skid_q;
        out_valid_d = 1'b1;
        skid_full_d = 1'b0;
      end else if (accept_s) begin
        out_d       = new_res_s;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_d      = new_res_s;
        skid_full_d = 1'b1;
      end else begin
        skid_full_d = skid_full_q;
      end
    end
  end

  // State registers; reset discards both the output and the skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_full_q <= 1'b0;
      skid_q      <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      skid_full_q <= skid_full_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready   = !skid_full_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = out_q.result;
  assign bus.zero       = out_q.zero;
  assign bus.negative   = out_q.negative;
  assign bus.carry      = out_q.carry;
  assign bus.overflow   = out_q.overflow;
  assign bus.illegal_op = out_q.illegal_op;
  assign bus.op_count   = cnt_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: the driver pushes hand-computed
// expected records on acceptance, an independent monitor pops and compares
// on every output transfer and checks hold-stability while stalled.
module tb_alu_exec_stage;

  logic clk;
  logic rst_n;

  alu_exec_if #(.WIDTH(32), .CNT_W(16)) bus_if ();

  alu_exec_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  logic [36:0] expq [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [36:0] out_vec();
    return {bus_if.result, bus_if.zero, bus_if.negative, bus_if.carry,
            bus_if.overflow, bus_if.illegal_op};
  endfunction

  // Monitor: compare on each transfer, check hold-stability while stalled.
  logic [36:0] held_v;
  bit          held;
  initial begin
    held = 1'b0;
    held_v = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else if (bus_if.out_valid) begin
        if (held) chk("stall_stable", {27'd0, out_vec()}, {27'd0, held_v});
        if (bus_if.out_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_output", 64'd1, 64'd0);
          end else begin
            chk("result_flags", {27'd0, out_vec()}, {27'd0, expq.pop_front()});
          end
          held = 1'b0;
        end else begin
          held_v = out_vec();
          held = 1'b1;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez, input logic en,
                       input logic ec, input logic ev, input logic ei);
    bit done = 1'b0;
    bus_if.in_valid   = 1'b1;
    bus_if.alucontrol = op;
    bus_if.src_a      = a;
    bus_if.src_b      = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus_if.in_ready) begin
        expq.push_back({er, ez, en, ec, ev, ei});
        exp_cnt++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus_if.in_valid   = 1'b0;
    bus_if.alucontrol = 3'b111;
    bus_if.src_a      = 32'hDEAD_BEEF;
    bus_if.src_b      = 32'h0BAD_F00D;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
    else chk("op_count", {48'd0, bus_if.op_count}, {48'd0, exp_cnt[15:0]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.in_valid   = 1'b0;
    bus_if.alucontrol = 3'b000;
    bus_if.src_a      = 32'd0;
    bus_if.src_b      = 32'd0;
    bus_if.out_ready  = 1'b1;
    idle(3);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    chk("rst_result", {32'd0, bus_if.result}, 64'd0);
    chk("rst_op_count", {48'd0, bus_if.op_count}, 64'd0);
    chk("rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);

    // Basic arithmetic and flags
    issue(3'b000, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b000, 32'h7FFF_FFFF,  32'h0000_0001,  32'h8000_0000,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(3'b000, 32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0000,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(3'b001, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(3'b001, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(3'b001, 32'h8000_0000,  32'h0000_0001,  32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    issue(3'b101, 32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0001,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(3'b101, 32'h0000_0001,  32'hFFFF_FFFF,  32'h0000_0000,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b011, 32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Backpressure: two ops fill output + skid, third must wait
    bus_if.out_ready = 1'b0;
    issue(3'b000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b000, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_in_ready_low", {63'd0, bus_if.in_ready}, 64'd0);
    chk("bp_out_valid", {63'd0, bus_if.out_valid}, 64'd1);
    chk("bp_head_result", {32'd0, bus_if.result}, 64'd2);
    bus_if.in_valid   = 1'b1;
    bus_if.alucontrol = 3'b000;
    bus_if.src_a      = 32'd3;
    bus_if.src_b      = 32'd3;
    idle(2);
    chk("bp_still_blocked", {63'd0, bus_if.in_ready}, 64'd0);
    chk("bp_op_count", {48'd0, bus_if.op_count}, {32'd0, exp_cnt});
    bus_if.out_ready = 1'b1;
    issue(3'b000, 32'd3, 32'd3, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("bp_drained", {63'd0, bus_if.out_valid}, 64'd0);

    // Reserved codes, then a legal op clears illegal_op
    issue(3'b110, 32'h1234,      32'h5678,      32'd0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(3'b010, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(3'b111, 32'h8000_0000, 32'h8000_0000, 32'd0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Asynchronous reset with output held and skid full
    bus_if.out_ready = 1'b0;
    issue(3'b000, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b001, 32'd4,  32'd1,  32'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_skid_full", {63'd0, bus_if.in_ready}, 64'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    chk("async_rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
    chk("async_rst_op_count", {48'd0, bus_if.op_count}, 64'd0);
    expq.delete();
    exp_cnt = 0;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
    chk("rel_op_count", {48'd0, bus_if.op_count}, 64'd0);
    idle(3);
    chk("rel_no_stale", {63'd0, bus_if.out_valid}, 64'd0);
    issue(3'b000, 32'h100, 32'h200, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && expq.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("scoreboard_empty", 64'(expq.size()), 64'd0);
    idle(1);
    chk("final_idle", {63'd0, bus_if.out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
